sseg_scan_ctrl: RTL and testbench
=================================

Name: sseg_scan_ctrl

Overview:
- Scan scheduler for the 4-digit multiplexed seven-segment display on the Nexys3.
- Accepts 16-bit display words from a producer over a valid/ready handshake and double-buffers them.
- Commits new words only at frame boundaries, so a frame never mixes old and new digits.
- Generates the digit rotation, anti-ghosting blanking, PWM brightness and active-low anode drive that feed the per-digit segment decoders.

Parameters:
- PRESCALE, 25000, clk cycles per digit slot (100 MHz gives 4 kHz per digit, 1 kHz per frame); must be at least BLANK+2.
- BLANK, 200, cycles at the start of each slot with all anodes off; must be at least 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- load_valid  input  1  producer has a word on load_value/load_dp/load_blank
- load_ready  output  1  block can accept a word
- load_value  input  16  four hex nibbles; [3:0] is digit 0 (rightmost)
- load_dp  input  4  decimal point per digit, 1 = lit
- load_blank  input  4  per-digit blank mask, 1 = anode never enabled
- enable  input  1  0 forces all anodes off; counters keep running
- bright  input  4  duty in sixteenths; 4'hF = 100% on
- digit  output  4  hex nibble for the currently scanned digit, to the segment decoder
- dp_out  output  1  decimal point for the current digit
- sseg_an  output  4  anode drive, active-low, one-hot-low or 4'b1111
- frame_tick  output  1  one-cycle pulse when the active word is (re)latched

Behaviour:
- Reset values, held while rst=1:
  - presc=0, sel=0, pwm=0.
  - Active and pending registers all zero; pend_full=0.
  - sseg_an=4'b1111, digit=0, dp_out=0, frame_tick=0.
  - load_ready=1 during and after reset, since it is combinational !pend_full.
- presc counts 0..PRESCALE-1 and wraps.
  - On wrap, sel increments mod 4 (0,1,2,3,0).
  - sel=3 wrapping to 0 is the frame boundary.
- pwm is a free-running 4-bit counter that increments every clk.
- Handshake:
  - A transfer occurs when load_valid && load_ready on a rising edge.
  - The word is written into the pending registers and pend_full is set.
  - The producer must hold its data stable while valid=1 and ready=0.
- Commit:
  - In the frame-boundary cycle with pend_full=1, pending is copied to active and pend_full is cleared.
  - frame_tick pulses on the following cycle.
  - If pend_full=0 at the boundary, active is unchanged and there is no frame_tick.
  - There is no bypass: a word accepted in the boundary cycle itself (pend_full was 0) is committed at the next boundary.
  - A full pending register cannot be overwritten, because ready=0.
- Outputs are registered, one cycle of latency from the counters.
  - digit and dp_out equal active nibble[sel] and active dp[sel].
  - sseg_an[sel]=0 only when all of these hold: presc >= BLANK, enable=1, active_blank[sel]=0, and (bright==4'hF or pwm < bright). Otherwise sseg_an=4'b1111.
  - bright=0 keeps the display dark.
  - At most one anode bit is 0 in any cycle.
- enable and bright are sampled every cycle; a change takes effect on the next output register update.
- Reset asserted mid-slot or mid-handshake:
  - Immediate return to reset values.
  - A pending word is discarded.
  - An in-flight word whose producer still holds valid is accepted afresh after release.
- Size estimate: roughly 150–200 RTL lines (counters, pending/active registers, output registers).

Test Plan:
- PRESCALE=8, BLANK=2, bright=F, enable=1; load 16'h1234, dp=4'b0001, blank=0 -> after the next boundary, frame_tick pulses once.
  - Each 8-cycle slot shows sseg_an=1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles.
  - digit is 4,3,2,1 across the four slots; dp_out=1 only in slot 0.
- Load A=16'hAAAA, then B=16'h5555 mid-frame -> B is accepted (load_ready 1→0).
  - A third word is stalled until the boundary; ready returns to 1 the cycle after the commit.
  - The display shows 5 from the next frame with no mixed digits.
- Load 16'hBEEF with valid asserted exactly in the boundary cycle and pend_full=0 -> digits update one frame later, and frame_tick fires at that later boundary.
- bright=4, PRESCALE=64, BLANK=2 -> during each non-blank window the anode is low exactly when pwm<4, i.e. 4 of every 16 cycles; bright=0 -> sseg_an stays 1111.
- blank=4'b0100, enable toggled to 0 for 10 cycles -> digit 2's anode is never driven, all anodes are 1111 while enable=0, and sel/presc keep advancing.
- Assert rst asynchronously mid-slot 2 with pend_full=1 -> sseg_an=1111 and outputs are zero immediately, load_ready=1, and scanning restarts at slot 0 after release.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - 4-digit seven-segment scan scheduler with frame-aligned double buffering
module sseg_scan_ctrl #(
  parameter int PRESCALE = 25000,
  parameter int BLANK    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  load_blank,
  input  logic        enable,
  input  logic [3:0]  bright,
  output logic [3:0]  digit,
  output logic        dp_out,
  output logic [3:0]  sseg_an,
  output logic        frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    pwm_q;

  logic [15:0]   pend_value_q, act_value_q;
  logic [3:0]    pend_dp_q, pend_blank_q, act_dp_q, act_blank_q;
  logic          pend_full_q;

  logic [3:0]    digit_q, digit_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          frame_tick_q;

  logic          slot_wrap, frame_end, load_fire, commit, lit;

  // Slot timing, handshake qualification and next output values
  always_comb begin
    slot_wrap = (presc_q == PW'(PRESCALE - 1));
    frame_end = slot_wrap && (sel_q == 2'd3);
    load_fire = load_valid && !pend_full_q;
    commit    = frame_end && pend_full_q;
    presc_d   = slot_wrap ? '0 : presc_q + 1'b1;
    sel_d     = slot_wrap ? sel_q + 2'd1 : sel_q;
    digit_d   = act_value_q[{sel_q, 2'b00} +: 4];
    dp_d      = act_dp_q[sel_q];
    // An anode only lights after the blanking window, when enabled, unmasked and inside the PWM duty
    lit       = (presc_q >= PW'(BLANK)) && enable && !act_blank_q[sel_q] &&
                ((bright == 4'hF) || (pwm_q < bright));
    an_d      = lit ? ~(4'b0001 << sel_q) : 4'b1111;
  end

  assign load_ready = !pend_full_q;
  assign digit      = digit_q;
  assign dp_out     = dp_q;
  assign sseg_an    = an_q;
  assign frame_tick = frame_tick_q;

  // Free-running slot prescaler, digit select and PWM phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      sel_q   <= 2'd0;
      pwm_q   <= 4'd0;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      pwm_q   <= pwm_q + 4'd1;
    end
  end

  // Pending buffer fills on a handshake and empties only at a frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_value_q <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_blank_q <= 4'h0;
      pend_full_q  <= 1'b0;
    end else if (load_fire) begin
      pend_value_q <= load_value;
      pend_dp_q    <= load_dp;
      pend_blank_q <= load_blank;
      pend_full_q  <= 1'b1;
    end else if (commit) begin
      pend_full_q  <= 1'b0;
    end
  end

  // Active word changes only at the frame boundary so a frame never mixes words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_value_q <= 16'h0000;
      act_dp_q    <= 4'h0;
      act_blank_q <= 4'h0;
    end else if (commit) begin
      act_value_q <= pend_value_q;
      act_dp_q    <= pend_dp_q;
      act_blank_q <= pend_blank_q;
    end
  end

  // Registered display outputs, one cycle behind the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q      <= 4'h0;
      dp_q         <= 1'b0;
      an_q         <= 4'b1111;
      frame_tick_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= commit;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;

  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_value = 16'h0000;
  logic [3:0]  load_dp = 4'h0;
  logic [3:0]  load_blank = 4'h0;
  logic        enable = 1'b1;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  digit;
  logic        dp_out;
  logic [3:0]  sseg_an;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;
  int n;

  sseg_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK(BLANK)) u_dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_dp(load_dp), .load_blank(load_blank),
    .enable(enable), .bright(bright),
    .digit(digit), .dp_out(dp_out), .sseg_an(sseg_an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; the DUT counters follow presc=n%8, sel=(n/8)%4, pwm=n%16
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // Expected anode drive after nn edges: outputs reflect the counters of edge nn-1
  function automatic logic [3:0] exp_an(input int nn, input logic en, input logic [3:0] br,
                                        input logic [3:0] bl);
    int m, p, s;
    m = nn - 1;
    if (m < 0) return 4'hF;
    p = m % 8;
    s = (m / 8) % 4;
    if (p >= BLANK && en && !bl[s] && (br == 4'hF || (m % 16) < int'(br)))
      return ~(4'b0001 << s);
    return 4'hF;
  endfunction

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 64; i++) begin
      if (n % 32 == ph) return;
      @(negedge clk);
    end
  endtask

  task automatic wait_tick(output int tn, output bit ok);
    ok = 0;
    tn = -1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (frame_tick) begin
        ok = 1;
        tn = n;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, output bit ok);
    load_value = v;
    load_dp    = d;
    load_blank = b;
    load_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (load_ready) ok = 1;
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sseg_an !== 4'hF) begin failures++; $display("FAIL reset_an got %b want 1111", sseg_an); end
    checks++; if (digit !== 4'h0) begin failures++; $display("FAIL reset_digit got %h want 0", digit); end
    checks++; if (dp_out !== 1'b0) begin failures++; $display("FAIL reset_dp got %b want 0", dp_out); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", load_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] an_tab [4];
    logic [3:0] dg_tab [4];
    logic       dp_tab [4];
    bit ok;
    int tn, s, p;
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    dg_tab = '{4'h4, 4'h3, 4'h2, 4'h1};
    dp_tab = '{1'b1, 1'b0, 1'b0, 1'b0};
    bright = 4'hF;
    enable = 1'b1;
    rst = 1'b0;
    load(16'h1234, 4'b0001, 4'b0000, ok);
    checks++; if (!ok || n !== 1) begin failures++; $display("FAIL basic_load got n=%0d want 1", n); end
    wait_phase(16);
    checks++; if (digit !== 4'h0 || frame_tick !== 1'b0) begin failures++;
      $display("FAIL basic_precommit got digit=%h tick=%b want 0 0", digit, frame_tick); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL basic_pend_ready got %b want 0", load_ready); end
    wait_tick(tn, ok);
    checks++; if (!ok || tn !== 32) begin failures++; $display("FAIL basic_tick got n=%0d want 32", tn); end
    @(negedge clk);
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL basic_tick_width got %b want 0", frame_tick); end
    for (int i = 0; i < 32; i++) begin
      s = ((n - 1) / 8) % 4;
      p = (n - 1) % 8;
      checks++; if (sseg_an !== ((p < 2) ? 4'hF : an_tab[s])) begin failures++;
        $display("FAIL basic_an n=%0d got %b want %b", n, sseg_an, (p < 2) ? 4'hF : an_tab[s]); end
      checks++; if (digit !== dg_tab[s]) begin failures++;
        $display("FAIL basic_digit n=%0d got %h want %h", n, digit, dg_tab[s]); end
      checks++; if (dp_out !== dp_tab[s]) begin failures++;
        $display("FAIL basic_dp n=%0d got %b want %b", n, dp_out, dp_tab[s]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, seen;
    int tn, rn;
    logic ft;
    logic [3:0] dg;
    load(16'hAAAA, 4'h0, 4'h0, ok);
    wait_tick(tn, ok);
    checks++; if (!ok || tn !== 96) begin failures++; $display("FAIL b2b_tick_a got n=%0d want 96", tn); end
    wait_phase(4);
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_b got %b want 1", load_ready); end
    load(16'h5555, 4'h0, 4'h0, ok);
    checks++; if (!ok || load_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_after_b got %b want 0", load_ready); end
    load_value = 16'hC3C3; load_dp = 4'h0; load_blank = 4'h0; load_valid = 1'b1;
    seen = 0; rn = -1; ft = 1'b0; dg = 4'h0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (load_ready) begin
        seen = 1; rn = n; ft = frame_tick; dg = digit;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    load_valid = 1'b0;
    checks++; if (!seen || rn !== 128) begin failures++; $display("FAIL b2b_stall got n=%0d want 128", rn); end
    checks++; if (ft !== 1'b1) begin failures++; $display("FAIL b2b_commit_tick got %b want 1", ft); end
    checks++; if (dg !== 4'hA) begin failures++; $display("FAIL b2b_old_digit got %h want a", dg); end
    for (int s = 0; s < 4; s++) begin
      wait_phase(5 + 8 * s);
      checks++; if (digit !== 4'h5 || sseg_an !== ~(4'b0001 << s)) begin failures++;
        $display("FAIL b2b_frame_b slot=%0d got digit=%h an=%b want 5 %b", s, digit, sseg_an, ~(4'b0001 << s)); end
    end
    wait_tick(tn, ok);
    checks++; if (!ok || tn !== 160) begin failures++; $display("FAIL b2b_tick_c got n=%0d want 160", tn); end
  endtask

  task automatic test_boundary_load();
    logic [3:0] dg_tab [4];
    bit ok;
    int tn;
    dg_tab = '{4'hF, 4'hE, 4'hE, 4'hB};
    wait_phase(31);
    checks++; if (load_ready !== 1'b1 || n !== 191) begin failures++;
      $display("FAIL bnd_ready got ready=%b n=%0d want 1 191", load_ready, n); end
    load_value = 16'hBEEF; load_dp = 4'h0; load_blank = 4'h0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL bnd_no_bypass_tick got %b want 0", frame_tick); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL bnd_accept got ready=%b want 0", load_ready); end
    wait_phase(5);
    checks++; if (digit !== 4'h3) begin failures++; $display("FAIL bnd_old_digit got %h want 3", digit); end
    wait_tick(tn, ok);
    checks++; if (!ok || tn !== 224) begin failures++; $display("FAIL bnd_tick got n=%0d want 224", tn); end
    for (int s = 0; s < 4; s++) begin
      wait_phase(5 + 8 * s);
      checks++; if (digit !== dg_tab[s]) begin failures++;
        $display("FAIL bnd_digit slot=%0d got %h want %h", s, digit, dg_tab[s]); end
    end
  endtask

  task automatic test_pwm();
    int lit;
    logic [3:0] br_tab [2];
    int cnt_tab [2];
    br_tab = '{4'd4, 4'd6};
    cnt_tab = '{8, 16};
    for (int k = 0; k < 2; k++) begin
      bright = br_tab[k];
      @(negedge clk);
      lit = 0;
      for (int i = 0; i < 64; i++) begin
        if (sseg_an !== 4'hF) lit++;
        checks++; if (sseg_an !== exp_an(n, 1'b1, br_tab[k], 4'h0)) begin failures++;
          $display("FAIL pwm_an bright=%0d n=%0d got %b want %b", br_tab[k], n, sseg_an, exp_an(n, 1'b1, br_tab[k], 4'h0)); end
        @(negedge clk);
      end
      checks++; if (lit !== cnt_tab[k]) begin failures++;
        $display("FAIL pwm_duty bright=%0d got %0d want %0d", br_tab[k], lit, cnt_tab[k]); end
    end
    bright = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      checks++; if (sseg_an !== 4'hF) begin failures++; $display("FAIL pwm_dark n=%0d got %b want 1111", n, sseg_an); end
      @(negedge clk);
    end
    bright = 4'hF;
  endtask

  task automatic test_blank_enable();
    bit ok;
    int tn;
    load(16'h1234, 4'h0, 4'b0100, ok);
    wait_tick(tn, ok);
    checks++; if (!ok) begin failures++; $display("FAIL blank_tick got none want pulse"); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++; if (sseg_an !== exp_an(n, 1'b1, 4'hF, 4'b0100)) begin failures++;
        $display("FAIL blank_an n=%0d got %b want %b", n, sseg_an, exp_an(n, 1'b1, 4'hF, 4'b0100)); end
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (sseg_an !== 4'hF) begin failures++; $display("FAIL enable_off n=%0d got %b want 1111", n, sseg_an); end
    end
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++; if (sseg_an !== exp_an(n, 1'b1, 4'hF, 4'b0100)) begin failures++;
        $display("FAIL enable_on n=%0d got %b want %b", n, sseg_an, exp_an(n, 1'b1, 4'hF, 4'b0100)); end
    end
  endtask

  task automatic test_reset_async();
    logic [3:0] dg_tab [4];
    bit ok;
    int tn;
    dg_tab = '{4'h6, 4'h7, 4'h8, 4'h9};
    load(16'h7777, 4'h0, 4'h0, ok);
    wait_tick(tn, ok);
    checks++; if (!ok) begin failures++; $display("FAIL arst_prep_tick got none want pulse"); end
    wait_phase(18);
    load(16'h8888, 4'h0, 4'h0, ok);
    checks++; if (sseg_an !== 4'b1011 || digit !== 4'h7 || load_ready !== 1'b0) begin failures++;
      $display("FAIL arst_pre got an=%b digit=%h ready=%b want 1011 7 0", sseg_an, digit, load_ready); end
    load_value = 16'h9876; load_dp = 4'h0; load_blank = 4'h0; load_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (sseg_an !== 4'hF) begin failures++; $display("FAIL arst_an got %b want 1111", sseg_an); end
    checks++; if (digit !== 4'h0 || dp_out !== 1'b0 || frame_tick !== 1'b0) begin failures++;
      $display("FAIL arst_outs got digit=%h dp=%b tick=%b want 0 0 0", digit, dp_out, frame_tick); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got %b want 1", load_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0 || sseg_an !== 4'hF) begin failures++;
      $display("FAIL arst_reaccept got ready=%b an=%b want 0 1111", load_ready, sseg_an); end
    wait_phase(3);
    checks++; if (sseg_an !== 4'b1110 || digit !== 4'h0) begin failures++;
      $display("FAIL arst_restart got an=%b digit=%h want 1110 0", sseg_an, digit); end
    wait_tick(tn, ok);
    checks++; if (!ok || tn !== 32) begin failures++; $display("FAIL arst_tick got n=%0d want 32", tn); end
    for (int s = 0; s < 4; s++) begin
      wait_phase(5 + 8 * s);
      checks++; if (digit !== dg_tab[s]) begin failures++;
        $display("FAIL arst_digit slot=%0d got %h want %h", s, digit, dg_tab[s]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundary_load();
    test_pwm();
    test_blank_enable();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
